bcd_add_sched: RTL and testbench
================================

# bcd_add_sched

Sequencer and arbiter that shares one 16-bit 8421-BCD adder (`add16bit_8421`: A, B, Cin, Y, Cout) between two requesters. Each requester submits an 8-digit (32-bit) BCD addition. The block runs it as two chained 16-bit passes through the single adder instance and returns the 8-digit sum and carry-out. It sits between the BCD arithmetic datapath and its clients and is the only instantiator of the adder.

## Interface
Parameters:
- `DIGITS`, 8: BCD digits per operand; fixed at 8 (two adder passes); other values unsupported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_ready`  out  2  one-hot one-cycle accept pulse.
- `req_a0`, `req_b0`  in  32 each  requester 0 operands, 8 BCD digits, digit 0 in [3:0].
- `req_a1`, `req_b1`  in  32 each  requester 1 operands.
- `req_cin`  in  2  per-requester carry-in.
- `rsp_valid`  out  1  result valid, held until accepted.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_sum`  out  32  8-digit BCD sum.
- `rsp_cout`  out  1  decimal carry-out of digit 7.
- `rsp_err`  out  1  invalid-digit flag; see Configuration.

## Operation
- FSM states: IDLE, LO, HI, RSP.
- IDLE:
  - If any `req_valid` is set, the arbiter picks a winner and pulses `req_ready[winner]` combinationally in that cycle.
  - Operands, cin and id are latched on the same edge. Next state is LO.
- Arbitration: round-robin, using a 1-bit `last` pointer.
  - If both requesters are valid, the grant goes to `~last`.
  - If only one is valid, that one wins.
  - `last` updates to the winner on acceptance. Reset value is `last=1`, so requester 0 wins the first contention.
- LO: adder inputs are A=a[15:0], B=b[15:0], Cin=latched cin. Register Y into sum[15:0] and Cout into the carry register. Next state is HI.
- HI: adder inputs are A=a[31:16], B=b[31:16], Cin=carry register. Register Y into sum[31:16] and Cout into `rsp_cout`. Next state is RSP.
- RSP: `rsp_valid`=1 and all `rsp_*` outputs are stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
  - No new request is accepted in RSP or in the cycle the response is consumed. The earliest accept is the following cycle, in IDLE.
- `req_ready` is 0 in every state except IDLE.
- Requests are not queued. A requester must hold `req_valid` and its operands stable until it sees `req_ready`.
- Arithmetic:
  - Each pass is pure 8421 BCD, per-digit modulo 10 with decimal carry.
  - Sum wraps mod 10^8; overflow is reported only via `rsp_cout`.
  - The carry chains LO to HI, so 00009999+00000001 gives 00010000.
- Reset (async, any state):
  - FSM goes to IDLE and `last`=1.
  - All outputs go to 0: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_err`=0.
  - An in-flight operation is discarded with no response.

## Timing
- Accept edge is T0. LO completes at T1, HI at T2, and `rsp_valid` rises after the T2 edge.
- Latency from accept to `rsp_valid` is 3 cycles.
- Best-case throughput is one operation per 4 cycles (IDLE, LO, HI, RSP with immediate `rsp_ready`).
- `rsp_ready` held low stalls in RSP indefinitely with outputs frozen.
- `rsp_ready` is ignored outside RSP.
- A simultaneous `req_valid` on both bits is resolved within the same IDLE cycle. The loser stays pending and is granted at the next IDLE.

## Configuration
- Macro `BCD_INVALID_CHECK_EN`.
- Defined:
  - At accept, every operand nibble of the winner is checked.
  - Any nibble > 9 sets a latched error bit, and `rsp_err`=1 with the response.
  - `rsp_sum` is forced to 0 and `rsp_cout` to 0 for that response.
  - The LO/HI passes still run, so latency is unchanged.
- Undefined: no check logic, `rsp_err` tied to 0, and invalid nibbles produce whatever the adder outputs.

## Test plan
- Requester 0: a=12345678, b=87654321, cin=0 -> after 3 cycles `rsp_valid`=1, id=0, sum=99999999, cout=0.
- Requester 1: a=99999999, b=00000000, cin=1 -> sum=00000000, cout=1.
- Requester 0: a=00009999, b=00000001, cin=0 -> sum=00010000, cout=0 (proves the LO-to-HI carry chain).
- Both requesters valid from reset, with `rsp_ready`=1:
  - Grant order is 0, then 1.
  - Then re-assert both: grant goes to 0 again, since last=1 after serving requester 1.
  - Expected: alternation 0,1,0,1, with `req_ready` one-hot and never asserted outside IDLE.
- Hold `rsp_ready`=0 for 5 cycles in RSP -> `rsp_*` outputs are stable and no `req_ready` pulse occurs. Drop `rst_n` during HI -> all outputs become 0 immediately, and after release the first contention is granted to requester 0.
- With `BCD_INVALID_CHECK_EN`: a=0000000A, b=00000001 -> `rsp_err`=1, sum=00000000, cout=0, latency 3. Without the macro, `rsp_err` stays 0.

Source files
------------

// File: rtl/bcd_add_sched.sv
// ============================================================================
// Module  : bcd_add_sched
// Brief   : Two-requester round-robin sequencer around one 16-bit 8421-BCD
//           adder; each 8-digit add runs as chained LO/HI passes.
//           Optional nibble validity check: define BCD_INVALID_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add16bit_8421 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Y,
    output logic        Cout
);
    logic [4:0] w_c;

    assign w_c[0] = Cin;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_digit
            logic [4:0] w_raw;
            assign w_raw      = {1'b0, A[4*g +: 4]} + {1'b0, B[4*g +: 4]} + {4'b0000, w_c[g]};
            assign w_c[g+1]   = (w_raw > 5'd9);
            assign Y[4*g +: 4] = w_c[g+1] ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
        end
    endgenerate

    assign Cout = w_c[4];
endmodule

module bcd_add_sched #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DIGITS*4-1:0]   req_a0,
    input  logic [DIGITS*4-1:0]   req_b0,
    input  logic [DIGITS*4-1:0]   req_a1,
    input  logic [DIGITS*4-1:0]   req_b1,
    input  logic [1:0]            req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DIGITS*4-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_err
);
    localparam int C_W  = DIGITS * 4;
    localparam int C_HW = C_W / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [C_W-1:0]  r_a;
    logic [C_W-1:0]  r_b;
    logic [C_W-1:0]  r_sum;
    logic            r_cin;
    logic            r_id;
    logic            r_last;
    logic            r_carry;
    logic            r_cout;
    logic            w_accept;
    logic            w_grant;
    logic            w_hi;
    logic            w_keep;
    logic [C_HW-1:0] w_add_a;
    logic [C_HW-1:0] w_add_b;
    logic            w_add_cin;
    logic [C_HW-1:0] w_add_y;
    logic            w_add_cout;
    logic [C_W-1:0]  w_sel_a;
    logic [C_W-1:0]  w_sel_b;

    // Round-robin: on contention the requester not served last time wins.
    assign w_grant = (&req_valid) ? ~r_last : req_valid[1];
    assign w_sel_a = w_grant ? req_a1 : req_a0;
    assign w_sel_b = w_grant ? req_b1 : req_b0;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_LO;
                end
            end
            S_LO:    w_next = S_HI;
            S_HI:    w_next = S_RSP;
            S_RSP:   if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Gated by rst_n so no accept pulse is visible while reset is held.
    assign req_ready = (w_accept && rst_n) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    assign w_hi      = (r_state == S_HI);
    assign w_add_a   = w_hi ? r_a[C_W-1:C_HW] : r_a[C_HW-1:0];
    assign w_add_b   = w_hi ? r_b[C_W-1:C_HW] : r_b[C_HW-1:0];
    assign w_add_cin = w_hi ? r_carry : r_cin;

    add16bit_8421 u_add (
        .A    (w_add_a),
        .B    (w_add_b),
        .Cin  (w_add_cin),
        .Y    (w_add_y),
        .Cout (w_add_cout)
    );

`ifdef BCD_INVALID_CHECK_EN
    logic r_err;

    function automatic logic has_bad_nibble(input logic [C_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= has_bad_nibble(w_sel_a) | has_bad_nibble(w_sel_b);
        end
    end

    assign w_keep  = ~r_err;
    assign rsp_err = r_err;
`else
    assign w_keep  = 1'b1;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cin   <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a    <= w_sel_a;
                r_b    <= w_sel_b;
                r_cin  <= req_cin[w_grant];
                r_id   <= w_grant;
                r_last <= w_grant;
            end
            if (r_state == S_LO) begin
                r_sum[C_HW-1:0] <= w_add_y & {C_HW{w_keep}};
                r_carry         <= w_add_cout;
            end
            if (r_state == S_HI) begin
                r_sum[C_W-1:C_HW] <= w_add_y & {C_HW{w_keep}};
                r_cout            <= w_add_cout & w_keep;
            end
        end
    end

    assign rsp_valid = (r_state == S_RSP);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_bcd_add_sched.sv
// ============================================================================
// Module  : tb_bcd_add_sched
// Brief   : Randomized self-checking bench for bcd_add_sched against a
//           decimal-integer reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_add_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    bcd_add_sched #(.DIGITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    function automatic longint bcd2int(input logic [31:0] v);
        longint r;
        r = 0;
        for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint n);
        logic [31:0] r;
        longint      t;
        t = n;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [31:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] rand_bcd();
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
        if (id == 0) begin
            req_a0 = a;
            req_b0 = b;
        end else begin
            req_a1 = a;
            req_b1 = b;
        end
        req_cin[id]   = cin;
        req_valid[id] = 1'b1;
    endtask

    // Asserts reset at the current time and checks every output is cleared.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b00) begin bad++; $display("FAIL %s req_ready got=%b exp=00", tag, req_ready); end
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL %s rsp_valid got=%b exp=0", tag, rsp_valid); end
        total++;
        if (rsp_id !== 1'b0) begin bad++; $display("FAIL %s rsp_id got=%b exp=0", tag, rsp_id); end
        total++;
        if (rsp_sum !== 32'h0) begin bad++; $display("FAIL %s rsp_sum got=%h exp=00000000", tag, rsp_sum); end
        total++;
        if (rsp_cout !== 1'b0) begin bad++; $display("FAIL %s rsp_cout got=%b exp=0", tag, rsp_cout); end
        total++;
        if (rsp_err !== 1'b0) begin bad++; $display("FAIL %s rsp_err got=%b exp=0", tag, rsp_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input int stall, input bit poke);
        longint      s;
        logic [31:0] esum;
        logic        ecout;
        logic        eerr;
        logic        chk_sum;
        logic        bad_in;
        logic [31:0] h_sum;
        logic        h_cout, h_id, h_err;
        int          n;

        s      = bcd2int(a) + bcd2int(b) + longint'(cin);
        esum   = int2bcd(s % 100000000);
        ecout  = (s >= 100000000);
        bad_in = has_bad(a) | has_bad(b);
`ifdef BCD_INVALID_CHECK_EN
        eerr    = bad_in;
        chk_sum = 1'b1;
        if (bad_in) begin
            esum  = 32'h0;
            ecout = 1'b0;
        end
`else
        eerr    = 1'b0;
        chk_sum = ~bad_in;
`endif
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        drive_req(id, a, b, cin);
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 20);
        total++;
        if (req_ready !== 2'(1 << id)) begin
            bad++; $display("FAIL grant req_ready got=%b exp=%b", req_ready, 2'(1 << id));
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (!rsp_valid) begin
                total++;
                if (req_ready !== 2'b00) begin bad++; $display("FAIL busy_ready got=%b exp=00", req_ready); end
            end
        end while (!rsp_valid && n < 10);
        total++;
        if (n != 3 || rsp_valid !== 1'b1) begin bad++; $display("FAIL latency got=%0d exp=3", n); end
        total++;
        if (rsp_id !== id[0]) begin bad++; $display("FAIL rsp_id got=%b exp=%b", rsp_id, id[0]); end
        total++;
        if (rsp_err !== eerr) begin bad++; $display("FAIL rsp_err got=%b exp=%b", rsp_err, eerr); end
        if (chk_sum) begin
            total++;
            if (rsp_sum !== esum) begin bad++; $display("FAIL rsp_sum a=%h b=%h cin=%b got=%h exp=%h", a, b, cin, rsp_sum, esum); end
            total++;
            if (rsp_cout !== ecout) begin bad++; $display("FAIL rsp_cout a=%h b=%h got=%b exp=%b", a, b, rsp_cout, ecout); end
        end
        h_sum = rsp_sum; h_cout = rsp_cout; h_id = rsp_id; h_err = rsp_err;
        if (poke && stall > 0) drive_req(1 - id, rand_bcd(), rand_bcd(), 1'b0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_sum !== h_sum || rsp_cout !== h_cout ||
                rsp_id !== h_id || rsp_err !== h_err || req_ready !== 2'b00) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got v=%b sum=%h rdy=%b exp v=1 sum=%h rdy=00",
                         k, rsp_valid, rsp_sum, req_ready, h_sum);
            end
        end
        rsp_ready = 1'b1;
        total++;
        if (req_ready !== 2'b00) begin bad++; $display("FAIL consume_ready got=%b exp=00", req_ready); end
        @(posedge clk); #1;
        if (poke) req_valid[1 - id] = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_release got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        do_reset("reset");
        req_valid = 2'b00;
    endtask

    task automatic test_directed();
        run_op(0, 32'h12345678, 32'h87654321, 1'b0, 0, 1'b0);
        run_op(1, 32'h99999999, 32'h00000000, 1'b1, 0, 1'b0);
        run_op(0, 32'h00009999, 32'h00000001, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, 1)), rand_bcd(), rand_bcd(),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    task automatic test_stall();
        run_op(1, rand_bcd(), rand_bcd(), 1'b1, 5, 1'b1);
    endtask

    task automatic test_arbitration();
        logic [31:0] a[2], b[2];
        logic        c[2];
        longint      s;
        int          n, m, w;
        @(negedge clk);
        do_reset("arb_reset");
        rsp_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            a[r] = rand_bcd(); b[r] = rand_bcd(); c[r] = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        drive_req(0, a[0], b[0], c[0]);
        drive_req(1, a[1], b[1], c[1]);
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 20);
            w = req_ready[1] ? 1 : 0;
            total++;
            if (req_ready !== 2'(1 << (g % 2))) begin
                bad++; $display("FAIL arb_order grant=%0d got=%b exp=%b", g, req_ready, 2'(1 << (g % 2)));
            end
            if (g > 0) begin
                total++;
                if (n != 1) begin bad++; $display("FAIL arb_throughput got=%0d exp=1", n); end
            end
            m = 0;
            do begin @(negedge clk); m++; end while (!rsp_valid && m < 10);
            s = bcd2int(a[w]) + bcd2int(b[w]) + longint'(c[w]);
            total++;
            if (m != 3 || rsp_id !== w[0] || rsp_sum !== int2bcd(s % 100000000)) begin
                bad++;
                $display("FAIL arb_rsp lat=%0d id=%b sum=%h exp lat=3 id=%b sum=%h",
                         m, rsp_id, rsp_sum, w[0], int2bcd(s % 100000000));
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n;
        run_op(1, rand_bcd(), rand_bcd(), 1'b0, 0, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        drive_req(0, 32'h55555555, 32'h44444444, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 20);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        do_reset("mid_reset");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL discard got=%b exp=0", rsp_valid); end
        end
        @(posedge clk); #1;
        drive_req(0, rand_bcd(), rand_bcd(), 1'b0);
        drive_req(1, rand_bcd(), rand_bcd(), 1'b0);
        @(negedge clk);
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL post_reset_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_invalid();
        run_op(0, 32'h0000000A, 32'h00000001, 1'b0, 0, 1'b0);
        run_op(1, 32'h12345678, 32'hF0000000, 1'b1, 1, 1'b0);
        run_op(0, 32'h00000009, 32'h00000001, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a0    = '0;
        req_b0    = '0;
        req_a1    = '0;
        req_b1    = '0;
        req_cin   = 2'b00;
        rsp_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_arbitration();
        test_reset_mid();
        test_invalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
